// File: rtl/s2_cfg_pkg.sv
// S2 cell configuration loader: shared constants and state encoding.
package s2_cfg_pkg;

    localparam int BITS_PER_CELL = 4;

    localparam int SLOT_D00 = 0;
    localparam int SLOT_D01 = 1;
    localparam int SLOT_D10 = 2;
    localparam int SLOT_D11 = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_COMMIT   = 2'd2,
        S_READBACK = 2'd3
    } state_e;

    function automatic int total_bits(input int n_cells);
        return n_cells * BITS_PER_CELL;
    endfunction

endpackage

// File: rtl/s2_cfg_counter.sv
// Bit position counter shared by frame load and serial readback.
module s2_cfg_counter #(
    parameter int TOTAL = 32,
    localparam int CW = $clog2(TOTAL + 1),
    localparam int IW = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [IW-1:0] idx_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last_o = (cnt_q == CW'(TOTAL - 1));
    assign idx_o  = cnt_q[IW-1:0];

    // Rolls back to zero on the terminal bit so it never points past the frame.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/s2_cfg_loader.sv
// Serial-in configuration writer for an S2 cell array, with
// atomic commit of the parallel word and serial readback.
module s2_cfg_loader
    import s2_cfg_pkg::*;
#(
    parameter int N_CELLS = 8
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic                             start,
    input  logic                             sin,
    input  logic                             sin_valid,
    output logic                             sin_ready,
    input  logic                             rb_req,
    output logic                             sout,
    output logic                             sout_valid,
    output logic [BITS_PER_CELL*N_CELLS-1:0] cfg_out,
    output logic                             cfg_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int TOTAL = total_bits(N_CELLS);
    localparam int IW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    state_e           state_q;
    logic [TOTAL-1:0] shadow_q;
    logic [TOTAL-1:0] shadow_d;
    logic [TOTAL-1:0] cfg_q;
    logic             cfg_valid_q;
    logic             done_q;
    logic             err_q;

    logic [IW-1:0]    idx;
    logic             cnt_last;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             accept;

    // A restart request outranks the data bit presented in the same cycle.
    assign accept    = (state_q == S_LOAD) & sin_valid & ~start;
    assign cnt_clear = ((state_q == S_IDLE) & (start | rb_req))
                     | ((state_q == S_LOAD) & start);
    assign cnt_inc   = accept | (state_q == S_READBACK);

    s2_cfg_counter #(
        .TOTAL (TOTAL)
    ) u_cnt (
        .clk     (clk),
        .clr     (clr),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .idx_o   (idx),
        .last_o  (cnt_last)
    );

    always_comb begin
        shadow_d = shadow_q;
        if (accept) begin
            shadow_d[idx] = sin;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                    end else if (rb_req) begin
                        state_q <= S_READBACK;
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        err_q <= 1'b1;
                    end else if (accept && cnt_last) begin
                        // Word lands with the last bit merged in, so the
                        // cells see it together with done.
                        cfg_q       <= shadow_d;
                        cfg_valid_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                end
                S_READBACK: begin
                    if (cnt_last) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sin_ready  = (state_q == S_LOAD);
    assign sout_valid = (state_q == S_READBACK);
    assign sout       = (state_q == S_READBACK) & cfg_q[idx];
    assign busy       = (state_q != S_IDLE);
    assign cfg_out    = cfg_q;
    assign cfg_valid  = cfg_valid_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_s2_cfg_loader.sv
// Self-checking bench for s2_cfg_loader with two cells (8-bit frames)
// against a word-level model of the committed configuration.
module tb_s2_cfg_loader;

    localparam int NC = 2;
    localparam int TOT = 4 * NC;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic           sin;
    logic           sin_valid;
    logic           sin_ready;
    logic           rb_req;
    logic           sout;
    logic           sout_valid;
    logic [TOT-1:0] cfg_out;
    logic           cfg_valid;
    logic           busy;
    logic           done;
    logic           err;

    int checks = 0;
    int errors = 0;

    // Reference model: the committed word and its valid flag.
    logic [TOT-1:0] m_cfg = '0;
    logic           m_valid = 1'b0;

    always #5 clk = ~clk;

    s2_cfg_loader #(
        .N_CELLS (NC)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready),
        .rb_req     (rb_req),
        .sout       (sout),
        .sout_valid (sout_valid),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic test_reset();
        clr = 1'b1; start = 0; sin = 0; sin_valid = 0; rb_req = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cfg_out, cfg_valid, busy, done, err, sin_ready, sout_valid, sout} !== '0) begin
            errors++;
            $display("FAIL reset: cfg=%h v=%b busy=%b done=%b err=%b rdy=%b sv=%b, want all 0",
                     cfg_out, cfg_valid, busy, done, err, sin_ready, sout_valid);
        end
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    // Loads one frame, optionally with random sin_valid gaps.
    task automatic test_load(input logic [TOT-1:0] data, input bit gaps);
        int n;
        int guard;
        logic [TOT-1:0] prev;
        prev = m_cfg;
        start = 1; sin_valid = 0;
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b1 || sin_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_enter: busy=%b rdy=%b want 1 1", busy, sin_ready);
        end
        n = 0; guard = 0;
        while (n < TOT && guard < 200) begin
            sin = data[n];
            sin_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            guard++;
            if (sin_valid) n++;
            if (n < TOT) begin
                checks++;
                if (cfg_out !== prev || done !== 1'b0) begin
                    errors++;
                    $display("FAIL load_hold: cfg=%h done=%b want %h 0", cfg_out, done, prev);
                end
            end
        end
        sin_valid = 0;
        if (n < TOT) begin
            checks++; errors++;
            $display("FAIL load_timeout: accepted %0d want %0d", n, TOT);
        end
        m_cfg = data; m_valid = 1'b1;
        checks++;
        if (done !== 1'b1 || cfg_out !== m_cfg || cfg_valid !== m_valid || sin_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit: done=%b cfg=%h v=%b rdy=%b want 1 %h 1 0",
                     done, cfg_out, cfg_valid, sin_ready, m_cfg);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cfg_out !== m_cfg) begin
            errors++;
            $display("FAIL post_commit: done=%b busy=%b cfg=%h want 0 0 %h",
                     done, busy, cfg_out, m_cfg);
        end
    endtask

    task automatic test_load_basic();
        bit b[TOT] = '{1, 0, 1, 1, 0, 0, 1, 0};
        logic [TOT-1:0] w;
        for (int i = 0; i < TOT; i++) w[i] = b[i];
        test_load(w, 1'b0);
        checks++;
        if (cfg_out !== 8'b0100_1101) begin
            errors++;
            $display("FAIL basic_word: cfg=%b want 01001101", cfg_out);
        end
    endtask

    task automatic test_restart();
        logic [TOT-1:0] data = 8'hA5;
        int errs = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 3; i++) begin
            sin = 1'($urandom_range(0, 1)); sin_valid = 1;
            @(negedge clk);
            errs += int'(err);
        end
        start = 1; sin = 1; sin_valid = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL restart_err: err=%b want 1", err);
        end
        errs += int'(err);
        for (int i = 0; i < TOT; i++) begin
            sin = data[i]; sin_valid = 1;
            @(negedge clk);
            errs += int'(err);
            if (i < TOT - 1) begin
                checks++;
                if (cfg_out !== m_cfg) begin
                    errors++;
                    $display("FAIL restart_hold: cfg=%h want %h", cfg_out, m_cfg);
                end
            end
        end
        sin_valid = 0;
        m_cfg = data; m_valid = 1'b1;
        checks++;
        if (done !== 1'b1 || cfg_out !== m_cfg) begin
            errors++;
            $display("FAIL restart_commit: done=%b cfg=%h want 1 %h", done, cfg_out, m_cfg);
        end
        @(negedge clk);
        checks++;
        if (errs != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_errcount: err pulses=%0d busy=%b want 1 0", errs, busy);
        end
    endtask

    task automatic test_readback(input bit poke);
        rb_req = 1;
        @(negedge clk);
        rb_req = 0;
        for (int i = 0; i < TOT; i++) begin
            checks++;
            if (sout_valid !== 1'b1 || sout !== m_cfg[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL readback_bit%0d: sv=%b sout=%b want 1 %b",
                         i, sout_valid, sout, m_cfg[i]);
            end
            start = poke && (i == 3);
            rb_req = poke && (i == 3);
            @(negedge clk);
        end
        start = 0; rb_req = 0;
        checks++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || cfg_out !== m_cfg) begin
            errors++;
            $display("FAIL readback_end: sv=%b busy=%b cfg=%h want 0 0 %h",
                     sout_valid, busy, cfg_out, m_cfg);
        end
    endtask

    task automatic test_clr_midframe();
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 5; i++) begin
            sin = 1'($urandom_range(0, 1)); sin_valid = 1;
            @(negedge clk);
        end
        sin_valid = 0;
        #2 clr = 1;
        #1;
        checks++;
        if ({cfg_out, cfg_valid, busy, done, err, sin_ready, sout_valid, sout} !== '0) begin
            errors++;
            $display("FAIL clr_async: cfg=%h v=%b busy=%b rdy=%b want all 0",
                     cfg_out, cfg_valid, busy, sin_ready);
        end
        @(negedge clk);
        clr = 0;
        m_cfg = '0; m_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_valid !== m_valid) begin
            errors++;
            $display("FAIL clr_idle: busy=%b v=%b want 0 0", busy, cfg_valid);
        end
    endtask

    task automatic test_start_rb_same();
        logic [TOT-1:0] data = TOT'($urandom);
        start = 1; rb_req = 1;
        @(negedge clk);
        start = 0; rb_req = 0;
        checks++;
        if (sin_ready !== 1'b1 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_wins: rdy=%b sv=%b want 1 0", sin_ready, sout_valid);
        end
        for (int i = 0; i < TOT; i++) begin
            sin = data[i]; sin_valid = 1;
            @(negedge clk);
            if (sout_valid !== 1'b0) begin
                checks++; errors++;
                $display("FAIL start_wins_sv: sv=%b want 0", sout_valid);
            end
        end
        sin_valid = 0;
        m_cfg = data; m_valid = 1'b1;
        checks++;
        if (done !== 1'b1 || cfg_out !== m_cfg || cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_wins_commit: done=%b cfg=%h want 1 %h", done, cfg_out, m_cfg);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_readback(1'b0);
        test_load_basic();
        test_load(8'h4D, 1'b1);
        test_restart();
        test_readback(1'b0);
        test_readback(1'b1);
        test_clr_midframe();
        test_readback(1'b0);
        test_start_rb_same();
        for (int k = 0; k < 6; k++) begin
            test_load(TOT'($urandom), 1'b1);
            test_readback(k[0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
